pc_gen: RTL and testbench
=========================

PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 Parameter XLEN, default 32, SHALL set the width of every PC-valued port.
REQ-002 Parameter STEP, default 4, SHALL set the sequential increment in bytes; legal values are 2, 4 and 8.
REQ-003 Parameter RESET_PC, default 32'h0000_0000, SHALL set the PC value loaded at reset.
REQ-004 Parameter BOOT_CYCLES, default 2, SHALL set the number of idle cycles after reset release before the first fetch; legal range is 1 to 15.
REQ-005 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-006 rst_n  input  1  SHALL be the reset, asynchronous and active-low.
REQ-007 stall_i  input  1  SHALL be the hazard-unit stall; 1 freezes the PC.
REQ-008 redirect_valid_i  input  1  SHALL be the branch/jump redirect request from EX.
REQ-009 redirect_pc_i  input  XLEN  SHALL be the branch/jump target.
REQ-010 trap_valid_i  input  1  SHALL be the trap/exception redirect request.
REQ-011 trap_pc_i  input  XLEN  SHALL be the trap vector.
REQ-012 ready_i  input  1  SHALL be asserted by IF when it accepts pc_o.
REQ-013 valid_o  output  1  SHALL indicate that pc_o is a valid fetch address.
REQ-014 pc_o  output  XLEN  SHALL be the current fetch PC.
REQ-015 pc_next_o  output  XLEN  SHALL equal pc_o + STEP, modulo 2^XLEN.
REQ-016 misalign_o  output  1  SHALL be a one-cycle pulse flagging a misaligned redirect target.

Function
REQ-017 FSM states: BOOT, RUN; reset enters BOOT.
REQ-018 BOOT: valid_o=0, PC held, boot counter increments each cycle; after BOOT_CYCLES cycles, transition to RUN.
REQ-019 RUN: valid_o=1.
REQ-020 Advance: in RUN with ready_i=1, stall_i=0 and no redirect, PC SHALL load pc_o+STEP on the next edge.
REQ-021 Hold: with ready_i=0 or stall_i=1 and no redirect, PC and valid_o SHALL remain unchanged.
REQ-022 Redirect priority: trap_valid_i > redirect_valid_i > sequential advance.
REQ-023 Redirect: the selected target loads PC on the next edge, regardless of stall_i and ready_i; latency is 1 cycle.
REQ-024 A redirect arriving in BOOT SHALL load PC, and the FSM SHALL remain in BOOT until the counter expires.
REQ-025 Alignment: a target with nonzero bits [log2(STEP)-1:0] SHALL load with those bits cleared, and misalign_o SHALL be 1 in the following cycle only.
REQ-026 Increment SHALL wrap: PC {XLEN{1'b1}}-(STEP-1) advances to 0, with no flag.
REQ-027 Simultaneous trap_valid_i and redirect_valid_i SHALL load trap_pc_i; misalignment is checked only on the selected target.
REQ-028 The output path SHALL be combinational from internal state only; there is no input-to-output combinational path.

Reset
REQ-029 On rst_n=0, asynchronously: state=BOOT, PC=RESET_PC, boot counter=0, valid_o=0, misalign_o=0, pc_next_o=RESET_PC+STEP.
REQ-030 Reset asserted mid-operation SHALL abandon any pending advance or redirect; after release, the full BOOT sequence repeats.

Structure
REQ-031 Shared package pc_pkg SHALL hold the state enum {BOOT, RUN}, the default XLEN, STEP and RESET_PC constants, and the alignment-mask function.
REQ-032 The sequential increment SHALL be the sub-module pc_step_adder (parameters XLEN and STEP; pc in, pc+STEP out), which feeds both pc_next_o and the advance path.

Verification
REQ-033 Reset release, ready_i=1, no stalls -> valid_o=0 for 2 cycles, then pc_o = 0x0, 0x4, 0x8 on consecutive cycles.
REQ-034 In RUN at pc 0x10, stall_i=1 for 3 cycles, then ready_i=0 for 2 cycles -> pc_o stays 0x10 for all 5 cycles, then reaches 0x14.
REQ-035 redirect_valid_i=1, redirect_pc_i=0x100, together with trap_valid_i=1, trap_pc_i=0x800, while stall_i=1 -> next pc_o=0x800.
REQ-036 redirect_pc_i=0x203 with STEP=4 -> next pc_o=0x200 and misalign_o=1 for exactly one cycle.
REQ-037 pc_o=0xFFFF_FFFC, advance -> pc_o=0x0 and pc_next_o=0x4.
REQ-038 rst_n pulsed low for half a cycle while a redirect is pending -> pc_o=RESET_PC and valid_o=0 immediately, and BOOT repeats.

Source files
------------

// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - shared state enum, default constants and alignment mask for the PC generator
package pc_pkg;

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } pc_state_t;

  localparam int          DEFAULT_XLEN     = 32;
  localparam int          DEFAULT_STEP     = 4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // Low-order bits that must be zero in an instruction address for a given step.
  function automatic logic [63:0] align_mask(input int step);
    return 64'(step - 1);
  endfunction

endpackage

// File: rtl/pc_gen_if.sv
// rtl/pc_gen_if.sv - control inputs and fetch-address outputs of the PC generator
interface pc_gen_if #(
  parameter int XLEN = 32
);

  logic            stall_i;
  logic            redirect_valid_i;
  logic [XLEN-1:0] redirect_pc_i;
  logic            trap_valid_i;
  logic [XLEN-1:0] trap_pc_i;
  logic            ready_i;
  logic            valid_o;
  logic [XLEN-1:0] pc_o;
  logic [XLEN-1:0] pc_next_o;
  logic            misalign_o;

  modport master (
    input  stall_i, redirect_valid_i, redirect_pc_i, trap_valid_i, trap_pc_i, ready_i,
    output valid_o, pc_o, pc_next_o, misalign_o
  );

  modport slave (
    output stall_i, redirect_valid_i, redirect_pc_i, trap_valid_i, trap_pc_i, ready_i,
    input  valid_o, pc_o, pc_next_o, misalign_o
  );

endinterface

// File: rtl/pc_step_adder.sv
// rtl/pc_step_adder.sv - sequential PC increment, wrapping modulo 2^XLEN
module pc_step_adder #(
  parameter int XLEN = 32,
  parameter int STEP = 4
) (
  input  logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus
);

  assign pc_plus = pc + XLEN'(STEP);

endmodule

// File: rtl/pc_gen.sv
// rtl/pc_gen.sv - fetch PC generator with boot delay, stall/hold, trap/branch redirect and alignment check
module pc_gen
  import pc_pkg::*;
#(
  parameter int              XLEN        = DEFAULT_XLEN,
  parameter int              STEP        = DEFAULT_STEP,
  parameter logic [XLEN-1:0] RESET_PC    = XLEN'(DEFAULT_RESET_PC),
  parameter int              BOOT_CYCLES = 2
) (
  input  logic     clk,
  input  logic     rst_n,
  pc_gen_if.master bus
);

  localparam logic [XLEN-1:0] LOW_MASK  = XLEN'(align_mask(STEP));
  localparam logic [3:0]      BOOT_LAST = 4'(BOOT_CYCLES - 1);

  pc_state_t       state;
  logic [3:0]      boot_cnt;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_plus;
  logic            misalign;

  logic            take_redirect;
  logic [XLEN-1:0] target;
  logic            advance;

  pc_step_adder #(
    .XLEN (XLEN),
    .STEP (STEP)
  ) u_step_adder (
    .pc      (pc),
    .pc_plus (pc_plus)
  );

  // Trap wins over branch; only the winning target is alignment-checked.
  assign take_redirect = bus.trap_valid_i | bus.redirect_valid_i;
  assign target        = bus.trap_valid_i ? bus.trap_pc_i : bus.redirect_pc_i;
  assign advance       = (state == RUN) & bus.ready_i & ~bus.stall_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= BOOT;
      boot_cnt <= 4'd0;
      pc       <= RESET_PC;
      misalign <= 1'b0;
    end else begin
      misalign <= 1'b0;
      if (take_redirect) begin
        pc       <= target & ~LOW_MASK;
        misalign <= |(target & LOW_MASK);
      end else if (advance) begin
        pc <= pc_plus;
      end

      // A redirect during BOOT moves the PC but never shortens the boot delay.
      if (state == BOOT) begin
        boot_cnt <= boot_cnt + 4'd1;
        if (boot_cnt == BOOT_LAST) begin
          state <= RUN;
        end
      end
    end
  end

  assign bus.valid_o    = (state == RUN);
  assign bus.pc_o       = pc;
  assign bus.pc_next_o  = pc_plus;
  assign bus.misalign_o = misalign;

endmodule

// File: tb/tb_pc_gen.sv
// tb/tb_pc_gen.sv - directed self-checking bench for pc_gen
module tb_pc_gen;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;

  pc_gen_if #(.XLEN(32)) bus ();

  pc_gen #(
    .XLEN        (32),
    .STEP        (4),
    .RESET_PC    (32'h0000_0000),
    .BOOT_CYCLES (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
    $fatal(1, "watchdog");
  end

  task automatic idle_inputs();
    bus.stall_i          = 1'b0;
    bus.redirect_valid_i = 1'b0;
    bus.redirect_pc_i    = 32'h0;
    bus.trap_valid_i     = 1'b0;
    bus.trap_pc_i        = 32'h0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    bus.ready_i = 1'b1;
    #12;
    n_cmp++;
    if (bus.valid_o !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", bus.valid_o); end
    n_cmp++;
    if (bus.pc_o !== 32'h0) begin n_bad++; $display("FAIL reset_pc: got %h want 00000000", bus.pc_o); end
    n_cmp++;
    if (bus.pc_next_o !== 32'h4) begin n_bad++; $display("FAIL reset_pc_next: got %h want 00000004", bus.pc_next_o); end
    n_cmp++;
    if (bus.misalign_o !== 1'b0) begin n_bad++; $display("FAIL reset_misalign: got %b want 0", bus.misalign_o); end
  endtask

  task automatic test_boot_sequence();
    logic [31:0] exp_pc [5] = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10};
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if (bus.valid_o !== 1'b0) begin n_bad++; $display("FAIL boot_valid[%0d]: got %b want 0", i, bus.valid_o); end
      @(negedge clk);
    end
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (bus.valid_o !== 1'b1 || bus.pc_o !== exp_pc[i]) begin
        n_bad++;
        $display("FAIL run_seq[%0d]: got valid=%b pc=%h want valid=1 pc=%h", i, bus.valid_o, bus.pc_o, exp_pc[i]);
      end
      if (i < 4) @(negedge clk);
    end
  endtask

  task automatic test_stall_hold();
    bus.stall_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp++;
      if (bus.pc_o !== 32'h10 || bus.valid_o !== 1'b1) begin
        n_bad++;
        $display("FAIL hold[%0d]: got valid=%b pc=%h want valid=1 pc=00000010", i, bus.valid_o, bus.pc_o);
      end
      if (i == 2) begin
        bus.stall_i = 1'b0;
        bus.ready_i = 1'b0;
      end
    end
    bus.ready_i = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (bus.pc_o !== 32'h14) begin n_bad++; $display("FAIL hold_release: got %h want 00000014", bus.pc_o); end
  endtask

  task automatic test_trap_priority();
    bus.stall_i          = 1'b1;
    bus.redirect_valid_i = 1'b1;
    bus.redirect_pc_i    = 32'h100;
    bus.trap_valid_i     = 1'b1;
    bus.trap_pc_i        = 32'h800;
    @(negedge clk);
    n_cmp++;
    if (bus.pc_o !== 32'h800 || bus.misalign_o !== 1'b0) begin
      n_bad++;
      $display("FAIL trap_priority: got pc=%h mis=%b want pc=00000800 mis=0", bus.pc_o, bus.misalign_o);
    end
    idle_inputs();
    bus.ready_i = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (bus.pc_o !== 32'h800) begin n_bad++; $display("FAIL trap_hold: got %h want 00000800", bus.pc_o); end
  endtask

  task automatic test_misalign();
    bus.redirect_valid_i = 1'b1;
    bus.redirect_pc_i    = 32'h203;
    @(negedge clk);
    idle_inputs();
    n_cmp++;
    if (bus.pc_o !== 32'h200 || bus.misalign_o !== 1'b1) begin
      n_bad++;
      $display("FAIL misalign_load: got pc=%h mis=%b want pc=00000200 mis=1", bus.pc_o, bus.misalign_o);
    end
    @(negedge clk);
    n_cmp++;
    if (bus.pc_o !== 32'h200 || bus.misalign_o !== 1'b0) begin
      n_bad++;
      $display("FAIL misalign_pulse: got pc=%h mis=%b want pc=00000200 mis=0", bus.pc_o, bus.misalign_o);
    end
    // Misaligned branch target must be ignored when an aligned trap wins.
    bus.redirect_valid_i = 1'b1;
    bus.redirect_pc_i    = 32'h103;
    bus.trap_valid_i     = 1'b1;
    bus.trap_pc_i        = 32'h900;
    @(negedge clk);
    idle_inputs();
    n_cmp++;
    if (bus.pc_o !== 32'h900 || bus.misalign_o !== 1'b0) begin
      n_bad++;
      $display("FAIL misalign_selected: got pc=%h mis=%b want pc=00000900 mis=0", bus.pc_o, bus.misalign_o);
    end
  endtask

  task automatic test_wrap();
    bus.redirect_valid_i = 1'b1;
    bus.redirect_pc_i    = 32'hFFFF_FFFC;
    @(negedge clk);
    idle_inputs();
    n_cmp++;
    if (bus.pc_o !== 32'hFFFF_FFFC || bus.pc_next_o !== 32'h0) begin
      n_bad++;
      $display("FAIL wrap_top: got pc=%h next=%h want pc=fffffffc next=00000000", bus.pc_o, bus.pc_next_o);
    end
    bus.ready_i = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (bus.pc_o !== 32'h0 || bus.pc_next_o !== 32'h4 || bus.misalign_o !== 1'b0) begin
      n_bad++;
      $display("FAIL wrap_zero: got pc=%h next=%h mis=%b want pc=00000000 next=00000004 mis=0",
               bus.pc_o, bus.pc_next_o, bus.misalign_o);
    end
  endtask

  task automatic test_back_to_back();
    bus.redirect_valid_i = 1'b1;
    bus.redirect_pc_i    = 32'h40;
    @(negedge clk);
    n_cmp++;
    if (bus.pc_o !== 32'h40) begin n_bad++; $display("FAIL b2b_first: got %h want 00000040", bus.pc_o); end
    bus.redirect_pc_i = 32'h80;
    @(negedge clk);
    idle_inputs();
    n_cmp++;
    if (bus.pc_o !== 32'h80) begin n_bad++; $display("FAIL b2b_second: got %h want 00000080", bus.pc_o); end
    @(negedge clk);
    n_cmp++;
    if (bus.pc_o !== 32'h84) begin n_bad++; $display("FAIL b2b_advance: got %h want 00000084", bus.pc_o); end
  endtask

  task automatic test_reset_mid();
    bus.redirect_valid_i = 1'b1;
    bus.redirect_pc_i    = 32'h300;
    #1;
    rst_n = 1'b0;
    idle_inputs();
    #1;
    n_cmp++;
    if (bus.pc_o !== 32'h0 || bus.valid_o !== 1'b0 || bus.pc_next_o !== 32'h4) begin
      n_bad++;
      $display("FAIL rst_async: got pc=%h valid=%b next=%h want pc=00000000 valid=0 next=00000004",
               bus.pc_o, bus.valid_o, bus.pc_next_o);
    end
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_cmp++;
      if (bus.valid_o !== (i == 1) || bus.pc_o !== 32'h0) begin
        n_bad++;
        $display("FAIL rst_reboot[%0d]: got valid=%b pc=%h want valid=%b pc=00000000", i, bus.valid_o, bus.pc_o, i == 1);
      end
    end
    @(negedge clk);
    n_cmp++;
    if (bus.pc_o !== 32'h4) begin n_bad++; $display("FAIL rst_resume: got %h want 00000004", bus.pc_o); end
  endtask

  task automatic test_boot_redirect();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n                = 1'b1;
    bus.redirect_valid_i = 1'b1;
    bus.redirect_pc_i    = 32'h500;
    @(negedge clk);
    idle_inputs();
    n_cmp++;
    if (bus.pc_o !== 32'h500 || bus.valid_o !== 1'b0) begin
      n_bad++;
      $display("FAIL boot_redirect: got pc=%h valid=%b want pc=00000500 valid=0", bus.pc_o, bus.valid_o);
    end
    @(negedge clk);
    n_cmp++;
    if (bus.pc_o !== 32'h500 || bus.valid_o !== 1'b1) begin
      n_bad++;
      $display("FAIL boot_redirect_run: got pc=%h valid=%b want pc=00000500 valid=1", bus.pc_o, bus.valid_o);
    end
    @(negedge clk);
    n_cmp++;
    if (bus.pc_o !== 32'h504) begin n_bad++; $display("FAIL boot_redirect_adv: got %h want 00000504", bus.pc_o); end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_boot_sequence();
    test_stall_hold();
    test_trap_priority();
    test_misalign();
    test_wrap();
    test_back_to_back();
    test_reset_mid();
    test_boot_redirect();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
